ifu_prefetch: RTL
=================

# ifu_prefetch

Parametrised instruction fetch unit that replaces the single-request fetch stage. It keeps up to DEPTH instruction reads in flight on an AXI4-Lite read channel (AR/R) and buffers returned words with their PCs in an internal FIFO. The buffered words are presented to the IDU over a valid/ready handshake. It sits between the PC/redirect logic and the IDU, and adds redirect flushing, stale-response discard and bus-fault reporting.

## Interface
- XLEN, 32: address/instruction width.
- DEPTH, 2: max (in-flight reads + buffered words); power of two, ≥1.
- RESET_PC, 32'h8000_0000: first fetch address.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  XLEN  new fetch address; low 2 bits ignored (treated as 0).
- araddr  out  XLEN  read address.
- arvalid  out  1  read address valid.
- arready  in  1  read address accepted.
- rdata  in  XLEN  read data.
- rresp  in  2  read response; nonzero = fault.
- rvalid  in  1  read data valid.
- rready  out  1  constant 1.
- inst_valid  out  1  instruction available to IDU.
- inst_ready  in  1  IDU accepts.
- inst  out  XLEN  instruction word (FIFO head).
- inst_pc  out  XLEN  PC of inst.
- inst_fault  out  1  head entry came back with rresp≠0.

## Operation
- State: fetch_pc, arvalid/araddr registers, inflight counter (accepted ARs not yet answered), stale counter (responses to discard), halted flag, FIFO of DEPTH entries {pc, data, fault} with count.
- Counters are $clog2(DEPTH)+1 bits wide; inflight + count + arvalid never exceeds DEPTH.
- Issue: if !halted and (inflight + count + arvalid), after this cycle's updates, < DEPTH, assert arvalid next cycle with araddr = fetch_pc.
- AR handshake (arvalid & arready): inflight+1; fetch_pc += 4, wrapping modulo 2^XLEN.
- araddr and arvalid stay stable while arvalid & !arready (AXI rule), including across a redirect.
- R handshake (rvalid always accepted): inflight−1.
  - If stale>0: stale−1, word dropped.
  - Else push {pc, rdata, rresp≠0} into the FIFO; pc is tracked by a response-PC register that advances by 4 per pushed word.
- Fault: a pushed fault entry sets halted. No new AR issues until a redirect; already-issued responses are still buffered.
- Pop: inst_valid & inst_ready removes the head.
- Redirect (highest priority):
  - FIFO cleared; any same-cycle push and pop are void.
  - fetch_pc and response-PC ← redirect_pc; halted ← 0.
  - stale ← inflight after this cycle's updates, plus 1 if an AR is pending unaccepted.
  - A pending AR completes with its old address; its response is dropped.
- Consecutive redirects accumulate stale correctly; the last redirect wins.

## Timing
- Reset values: arvalid=0, araddr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, inst_fault=0, rready=1, inflight=stale=count=0, halted=0, fetch_pc=RESET_PC.
- First arvalid=1 in the first cycle after rst_n deasserts.
- Reset asserted mid-transaction returns everything to reset values immediately. The external bus is reset in the same domain.
- Issue latency: one cycle from credit becoming available to arvalid. Back-to-back ARs are possible; arvalid stays high across handshakes while credit remains.
- Response to IDU: rvalid in cycle t → inst_valid at t+1 (registered FIFO, no bypass).
- Redirect in cycle t:
  - inst_valid=0 at t+1.
  - If no AR is pending, arvalid with araddr=redirect_pc at t+1.
  - Otherwise the new AR follows, at the earliest, the cycle after the old AR is accepted.
- Full FIFO: issue stalls; inst_valid is unaffected.
- Empty FIFO: inst_valid=0 and inst/inst_pc hold their last value.

## Test plan
- Reset, arready=1, 1-cycle memory returning addr^32'hFFFF_FFFF, inst_ready=1 → araddr sequence 8000_0000, 8000_0004, …; inst/inst_pc pairs match in order; inst_valid continuous after fill.
- DEPTH=2, inst_ready=0 → exactly 2 ARs accepted, then arvalid=0; raise inst_ready → issuing resumes one cycle after the first pop.
- Redirect to 8000_0100 with 2 reads in flight and 1 AR pending unaccepted → those 3 responses are never presented; first inst_pc=8000_0100.
- Response with rresp=2'b10 at pc 8000_0008 → inst_fault=1 for that entry, no further AR; redirect to 8000_0000 → fetch resumes and fault is cleared.
- fetch_pc=FFFF_FFFC → next araddr=0000_0000.
- rst_n pulsed low mid-burst → all outputs at reset values asynchronously; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifu_prefetch.sv
// Prefetching instruction fetch unit: keeps several AXI4-Lite reads in flight
// and buffers returned words with their PCs for the decoder.
module ifu_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] araddr,
    output logic            arvalid,
    input  logic            arready,
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      rresp,
    input  logic            rvalid,
    output logic            rready,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [XLEN-1:0] r_araddr;
    logic            r_arvalid;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_stale;
    logic [CW-1:0]   r_count;
    logic            r_halted;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [XLEN-1:0] r_fpc   [DEPTH];
    logic [XLEN-1:0] r_fdata [DEPTH];
    logic            r_ffault[DEPTH];
    logic [XLEN-1:0] r_hold_data;
    logic [XLEN-1:0] r_hold_pc;
    logic            r_hold_fault;

    logic            w_ar_hs;
    logic            w_ar_hold;
    logic            w_drop;
    logic            w_fault;
    logic            w_push;
    logic            w_pop;
    logic            w_halted_n;
    logic            w_issue;
    logic [CW-1:0]   w_inflight_n;
    logic [CW-1:0]   w_count_n;
    logic [CW-1:0]   w_stale_n;
    logic [XLEN-1:0] w_redir_pc;
    logic [XLEN-1:0] w_fpc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    assign w_redir_pc = redirect_pc & ~XLEN'(3);

    always_comb begin
        w_ar_hs      = r_arvalid & arready;
        w_ar_hold    = r_arvalid & ~arready;
        w_drop       = rvalid & (r_stale != '0);
        w_fault      = rresp != 2'b00;
        w_push       = rvalid & ~w_drop & ~redirect_valid;
        w_pop        = (r_count != '0) & inst_ready & ~redirect_valid;
        w_inflight_n = r_inflight + CW'(w_ar_hs) - CW'(rvalid);
        w_count_n    = redirect_valid ? '0
                     : r_count + CW'(w_push) - CW'(w_pop);
        // a pending AR will still be answered, so it is owed a discard too
        w_stale_n    = redirect_valid ? w_inflight_n + CW'(w_ar_hold)
                     : r_stale - CW'(w_drop);
        w_halted_n   = ~redirect_valid & (r_halted | (w_push & w_fault));
        w_fpc        = redirect_valid ? w_redir_pc : r_fetch_pc;
        w_issue      = ~w_ar_hold & ~w_halted_n &
                       (({1'b0, w_inflight_n} + {1'b0, w_count_n})
                        < (CW+1)'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc   <= RESET_PC;
            r_resp_pc    <= RESET_PC;
            r_araddr     <= RESET_PC;
            r_arvalid    <= 1'b0;
            r_inflight   <= '0;
            r_stale      <= '0;
            r_count      <= '0;
            r_halted     <= 1'b0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_hold_data  <= '0;
            r_hold_pc    <= '0;
            r_hold_fault <= 1'b0;
        end else begin
            r_inflight <= w_inflight_n;
            r_count    <= w_count_n;
            r_stale    <= w_stale_n;
            r_halted   <= w_halted_n;
            r_arvalid  <= w_ar_hold | w_issue;
            if (w_issue) begin
                r_araddr   <= w_fpc;
                r_fetch_pc <= w_fpc + XLEN'(4);
            end else begin
                r_fetch_pc <= w_fpc;
            end
            if (redirect_valid) begin
                r_resp_pc <= w_redir_pc;
                r_rd_ptr  <= r_wr_ptr;
            end else begin
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + XLEN'(4);
                    r_wr_ptr  <= ptr_inc(r_wr_ptr);
                end
                if (w_pop)
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (r_count != '0) begin
                r_hold_data  <= r_fdata[r_rd_ptr];
                r_hold_pc    <= r_fpc[r_rd_ptr];
                r_hold_fault <= r_ffault[r_rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fpc[r_wr_ptr]    <= r_resp_pc;
            r_fdata[r_wr_ptr]  <= rdata;
            r_ffault[r_wr_ptr] <= w_fault;
        end
    end

    // outputs keep the last presented entry while the buffer is empty
    assign inst_valid = r_count != '0;
    assign inst       = inst_valid ? r_fdata[r_rd_ptr]  : r_hold_data;
    assign inst_pc    = inst_valid ? r_fpc[r_rd_ptr]    : r_hold_pc;
    assign inst_fault = inst_valid ? r_ffault[r_rd_ptr] : r_hold_fault;
    assign araddr     = r_araddr;
    assign arvalid    = r_arvalid;
    assign rready     = 1'b1;
endmodule
